mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 64: max cycles in REQ before the access is abandoned.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports MemReadM, MemWriteM  input  1 each  load/store request from the memory stage.
REQ-005 SHALL have port Funct3M  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 SHALL have ports ALUResultM (byte address) and WriteDataM (store data)  input  32 each.
REQ-007 SHALL have port TruncResultM  output  32  registered, extended load result feeding the MEM->WB register.
REQ-008 SHALL have ports StallM, MisalignM, TimeoutM  output  1 each  pipeline stall, misaligned-access flag, timeout flag.
REQ-009 SHALL have ports dmem_req, dmem_we  output  1 each; dmem_addr, dmem_wdata  output  32 each; dmem_be  output  4.
REQ-010 SHALL have ports dmem_ack  input  1 and dmem_rdata  input  32  data-memory response.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, DONE.
REQ-012 Access pending = MemReadM|MemWriteM; both high SHALL be treated as a write.
REQ-013 Misaligned = H/HU/SH with addr[0]=1, or W with addr[1:0]!=0; Funct3 011/110/111 SHALL be treated as W.
REQ-014 IDLE, pending, aligned: SHALL go to REQ; StallM=1 combinationally in that cycle.
REQ-015 IDLE, pending, misaligned: SHALL stay IDLE, no request, MisalignM=1 that cycle only, StallM=0, TruncResultM unchanged.
REQ-016 In REQ: dmem_req=1; dmem_addr={addr[31:2],2'b00}; dmem_we, dmem_be, dmem_wdata SHALL be registered on entry and held stable until leaving REQ.
REQ-017 dmem_be SHALL be: B 0001<<addr[1:0]; H 0011 (addr[1]=0) or 1100; W 1111; all-ones for loads.
REQ-018 dmem_wdata SHALL replicate the byte (B) to all 4 lanes, the halfword (H) to both halves, W unchanged.
REQ-019 REQ with dmem_ack=1 SHALL go to DONE; for loads, TruncResultM SHALL load the lane selected by addr[1:0] from dmem_rdata, sign-extended (B/H) or zero-extended (BU/HU), W unchanged.
REQ-020 Ack in the first REQ cycle SHALL be accepted (zero-wait memory: 3-cycle load/store: IDLE, REQ, DONE).
REQ-021 A 6-bit-minimum wait counter SHALL clear on REQ entry and count each REQ cycle without ack; reaching ACK_TIMEOUT SHALL go to DONE, drop dmem_req, set TruncResultM=0 for loads, and assert TimeoutM for the DONE cycle.
REQ-022 StallM SHALL be 1 in REQ, 0 in DONE; DONE SHALL unconditionally return to IDLE next cycle, so the pipeline advances exactly once per access.
REQ-023 dmem_ack in IDLE or DONE SHALL be ignored.
REQ-024 Stores SHALL leave TruncResultM unchanged.
REQ-025 Non-memory instructions in IDLE: no request, StallM=0, outputs unchanged.

Reset
REQ-026 On reset: state IDLE, TruncResultM=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, counter=0, TimeoutM=0.
REQ-027 Reset mid-REQ SHALL drop dmem_req next edge; a later ack for that access SHALL be ignored.
REQ-028 Reset SHALL take priority over every FSM transition in the same cycle.

Verification
REQ-029 LB addr 0x103, ack on first REQ cycle, rdata 0x80FF_0000 -> TruncResultM=0xFFFF_FF80, StallM high 2 cycles then low 1.
REQ-030 SH addr 0x202, WriteDataM 0x0000_BEEF -> dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_addr=0x200, dmem_we=1.
REQ-031 LW addr 0x101 -> MisalignM=1 one cycle, dmem_req never asserted, StallM=0.
REQ-032 LHU addr 0x300, ack after 5 wait cycles, rdata 0x1234_9ABC -> dmem_req high 6 cycles, TruncResultM=0x0000_9ABC.
REQ-033 LW with ack never asserted, ACK_TIMEOUT=64 -> dmem_req drops after 64 REQ cycles, TimeoutM=1 one cycle, TruncResultM=0.
REQ-034 Reset during REQ with ack the next cycle -> state IDLE, dmem_req=0, TruncResultM=0.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store sequencer with a request/ack data-memory
//               port, size/sign handling, misalignment detect and ack timeout.
// Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] TruncResultM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        TimeoutM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam int c_CNT_W = ($clog2(ACK_TIMEOUT + 1) > 6) ? $clog2(ACK_TIMEOUT + 1) : 6;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_CNT_W-1:0]   r_wait_cnt;
  logic [1:0]           r_off;
  logic [2:0]           r_funct3;
  logic                 w_pending;
  logic                 w_misalign;
  logic                 w_start;
  logic                 w_ack_ok;
  logic                 w_expire;
  logic [3:0]           w_be;
  logic [31:0]          w_wdata;
  logic [31:0]          w_lane;
  logic [31:0]          w_load;

  // Size decode uses Funct3[1:0] only, so 011/110/111 fall into the word case.
  always_comb begin
    w_pending  = MemReadM | MemWriteM;
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = WriteDataM;
    case (Funct3M[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ALUResultM[1:0];
        w_wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        w_misalign = ALUResultM[0];
        w_be       = ALUResultM[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{WriteDataM[15:0]}};
      end
      default: begin
        w_misalign = |ALUResultM[1:0];
      end
    endcase
    if (!MemWriteM) begin
      w_be = 4'b1111;
    end
  end

  always_comb begin
    w_lane = dmem_rdata >> {r_off, 3'b000};
    w_load = dmem_rdata;
    case (r_funct3[1:0])
      2'b00:   w_load = r_funct3[2] ? {24'b0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_load = r_funct3[2] ? {16'b0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
      default: w_load = dmem_rdata;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    StallM    = 1'b0;
    MisalignM = 1'b0;
    dmem_req  = 1'b0;
    w_start   = 1'b0;
    w_ack_ok  = 1'b0;
    w_expire  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pending) begin
          if (w_misalign) begin
            MisalignM = 1'b1;
          end else begin
            w_start = 1'b1;
            StallM  = 1'b1;
            w_next  = REQ;
          end
        end
      end
      REQ: begin
        StallM   = 1'b1;
        dmem_req = 1'b1;
        if (dmem_ack) begin
          w_ack_ok = 1'b1;
          w_next   = DONE;
        end else if (r_wait_cnt == c_LAST) begin
          w_expire = 1'b1;
          w_next   = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wait_cnt   <= '0;
      r_off        <= 2'b00;
      r_funct3     <= 3'b000;
      TruncResultM <= 32'h0;
      TimeoutM     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'h0;
      dmem_wdata   <= 32'h0;
      dmem_be      <= 4'b0000;
    end else begin
      r_state  <= w_next;
      TimeoutM <= w_expire;
      if (w_start) begin
        dmem_addr  <= {ALUResultM[31:2], 2'b00};
        dmem_we    <= MemWriteM;
        dmem_be    <= w_be;
        dmem_wdata <= w_wdata;
        r_off      <= ALUResultM[1:0];
        r_funct3   <= Funct3M;
        r_wait_cnt <= '0;
      end else if (r_state == REQ && !dmem_ack) begin
        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
      end
      // Loads only; an abandoned load returns zero.
      if (w_ack_ok && !dmem_we) begin
        TruncResultM <= w_load;
      end else if (w_expire && !dmem_we) begin
        TruncResultM <= 32'h0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit against an access-level model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int c_TMO   = 64;
  localparam int c_NEVER = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  Funct3M = 3'b000;
  logic [31:0] ALUResultM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic [31:0] TruncResultM;
  logic        StallM;
  logic        MisalignM;
  logic        TimeoutM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_trunc = 32'h0;

  mem_access_unit #(.ACK_TIMEOUT(c_TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemReadM     (MemReadM),
    .MemWriteM    (MemWriteM),
    .Funct3M      (Funct3M),
    .ALUResultM   (ALUResultM),
    .WriteDataM   (WriteDataM),
    .TruncResultM (TruncResultM),
    .StallM       (StallM),
    .MisalignM    (MisalignM),
    .TimeoutM     (TimeoutM),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: access size in bytes, alignment, lanes and extension.
  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input bit is_wr, input logic [2:0] f3, input logic [31:0] addr);
    int n = nbytes(f3);
    if (!is_wr) return 4'hF;
    return 4'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r = 32'h0;
    int n = nbytes(f3);
    for (int i = 0; i < 4; i++) r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    int     n = nbytes(f3);
    longint v;
    v = (longint'(rd) >> (8 * (addr % 4))) & ((64'd1 << (8 * n)) - 1);
    if (!f3[2] && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic drop_inputs();
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    Funct3M    = 3'($urandom);
    ALUResultM = $urandom;
    WriteDataM = $urandom;
  endtask

  // Entered and left at posedge+1.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int delay, input logic [31:0] rdata);
    bit mis, ack, is_wr, tmo;
    int n;
    is_wr = wr;
    mis   = model_misaligned(f3, addr);
    tmo   = delay >= c_TMO;
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    @(negedge clk);
    check_val("idle_misalign", MisalignM, mis);
    check_val("idle_stall", StallM, !mis);
    check_val("idle_req", dmem_req, 0);
    if (mis) begin
      @(posedge clk); #1;
      drop_inputs();
      @(negedge clk);
      check_val("mis_req", dmem_req, 0);
      check_val("mis_flag_once", MisalignM, 0);
      check_val("mis_trunc", TruncResultM, exp_trunc);
      @(posedge clk); #1;
      return;
    end
    n = 0;
    ack = 1'b0;
    while (!ack && n < c_TMO) begin
      @(posedge clk); #1;
      ack = (n == delay);
      dmem_ack   = ack;
      dmem_rdata = ack ? rdata : $urandom;
      @(negedge clk);
      check_val("req_req", dmem_req, 1);
      check_val("req_stall", StallM, 1);
      check_val("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      check_val("req_we", dmem_we, is_wr);
      check_val("req_be", dmem_be, model_be(is_wr, f3, addr));
      if (is_wr) check_val("req_wdata", dmem_wdata, model_wdata(f3, wd));
      n++;
    end
    @(posedge clk); #1;
    dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    if (!is_wr) exp_trunc = tmo ? 32'h0 : model_load(f3, addr, rdata);
    @(negedge clk);
    check_val("done_stall", StallM, 0);
    check_val("done_req", dmem_req, 0);
    check_val("done_timeout", TimeoutM, tmo);
    check_val("done_trunc", TruncResultM, exp_trunc);
    @(posedge clk); #1;
    drop_inputs();
    @(negedge clk);
    check_val("post_stall", StallM, 0);
    check_val("post_req", dmem_req, 0);
    check_val("post_timeout", TimeoutM, 0);
    check_val("post_trunc", TruncResultM, exp_trunc);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
  endtask

  task automatic idle_cycles(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      drop_inputs();
      dmem_ack = 1'($urandom); dmem_rdata = $urandom;
      @(negedge clk);
      check_val("nop_stall", StallM, 0);
      check_val("nop_req", dmem_req, 0);
      check_val("nop_trunc", TruncResultM, exp_trunc);
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
  endtask

  task automatic reset_mid_req();
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h400; dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_req_before", dmem_req, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    drop_inputs();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    exp_trunc = 32'h0;
    @(negedge clk);
    check_val("rst_req", dmem_req, 0);
    check_val("rst_stall", StallM, 0);
    check_val("rst_trunc", TruncResultM, 0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check_val("rst_late_ack_trunc", TruncResultM, 0);
    check_val("rst_late_ack_req", dmem_req, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] f3_tab [8];
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_val("rst_trunc0", TruncResultM, 0);
    check_val("rst_req0", dmem_req, 0);
    check_val("rst_we0", dmem_we, 0);
    check_val("rst_addr0", dmem_addr, 0);
    check_val("rst_wdata0", dmem_wdata, 0);
    check_val("rst_be0", dmem_be, 0);
    check_val("rst_tmo0", TimeoutM, 0);
    check_val("rst_stall0", StallM, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(2);

    access(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_0000);
    check_val("lb_result", TruncResultM, 32'hFFFF_FF80);
    access(0, 1, 3'b001, 32'h202, 32'h0000_BEEF, 0, 32'h0);
    access(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
    access(1, 0, 3'b101, 32'h300, 32'h0, 5, 32'h1234_9ABC);
    check_val("lhu_result", TruncResultM, 32'h0000_9ABC);
    access(1, 0, 3'b010, 32'h500, 32'h0, c_NEVER, 32'h0);
    access(1, 0, 3'b010, 32'h504, 32'h0, 3, 32'hCAFE_F00D);
    access(1, 0, 3'b010, 32'h508, 32'h0, c_TMO - 1, 32'h7654_3210);
    access(1, 1, 3'b000, 32'h60D, 32'h0000_00A5, 1, 32'h0);
    access(0, 1, 3'b010, 32'h700, 32'h1122_3344, c_NEVER, 32'h0);
    reset_mid_req();

    for (int k = 0; k < 200; k++) begin
      bit          rd, wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          dly;
      case ($urandom_range(0, 3))
        0, 1:    begin rd = 1'b1; wr = 1'b0; end
        2:       begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      f3   = f3_tab[$urandom_range(0, 7)];
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      dly  = ($urandom_range(0, 39) == 0) ? c_NEVER : $urandom_range(0, 6);
      access(rd, wr, f3, addr, $urandom, dly, $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
